// File: rtl/vehicle_lane_scheduler.sv
// Shares one Bike/Bike/Car/Bike/Car detector across NUM_LANES lanes with per-lane saved state.
// Define VLS_FIXED_PRIORITY_EN for lowest-index-wins arbitration; default is round-robin.
module vehicle_lane_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] lane_valid,
  input  logic [NUM_LANES-1:0] lane_data,
  input  logic [NUM_LANES-1:0] lane_clear,
  output logic [NUM_LANES-1:0] lane_ready,
  output logic                 match_valid,
  output logic [LANE_W-1:0]    match_lane,
  output logic [7:0]           match_total
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_B     = 3'd1,
    S_BB    = 3'd2,
    S_BBC   = 3'd3,
    S_BBCB  = 3'd4,
    S_BBCBC = 3'd5
  } lane_state_t;

  // bike=1 is a Bike symbol, bike=0 a Car symbol.
  function automatic lane_state_t step_state(input lane_state_t cur, input logic bike);
    lane_state_t nxt;
    case (cur)
      IDLE:    nxt = bike ? S_B    : IDLE;
      S_B:     nxt = bike ? S_BB   : IDLE;
      S_BB:    nxt = bike ? S_BB   : S_BBC;
      S_BBC:   nxt = bike ? S_BBCB : IDLE;
      S_BBCB:  nxt = bike ? S_BB   : S_BBCBC;
      S_BBCBC: nxt = bike ? S_B    : IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  logic [NUM_LANES-1:0] eligible;
  logic [NUM_LANES-1:0] lane_hit;
  logic                 grant_found;
  logic [LANE_W-1:0]    grant_idx;
  logic                 match_hit;

  logic                 match_valid_reg;
  logic [LANE_W-1:0]    match_lane_reg;
  logic [7:0]           match_total_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lane_state_t state_reg;
      lane_state_t state_next;
      lane_state_t state_step;

      assign eligible[gi]   = lane_valid[gi] & ~lane_clear[gi];
      assign lane_ready[gi] = grant_found && (grant_idx == LANE_W'(gi));
      assign state_step     = step_state(state_reg, lane_data[gi]);
      assign lane_hit[gi]   = lane_ready[gi] && (state_step == S_BBCBC);

      // Clear dominates: a cleared lane is never granted, so its symbol stays pending.
      always_comb begin
        state_next = state_reg;
        if (lane_clear[gi]) begin
          state_next = IDLE;
        end else if (lane_ready[gi]) begin
          state_next = state_step;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= IDLE;
        end else begin
          state_reg <= state_next;
        end
      end
    end
  endgenerate

`ifdef VLS_FIXED_PRIORITY_EN
  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_found = 1'b1;
        grant_idx   = LANE_W'(i);
      end
    end
  end
`else
  logic [LANE_W-1:0] rr_ptr_reg;
  logic [LANE_W-1:0] rr_ptr_next;

  // Scan offsets downward so the eligible lane nearest rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_LANES) begin
        idx = idx - NUM_LANES;
      end
      if (eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = LANE_W'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_found) begin
      rr_ptr_next = (grant_idx == LANE_W'(NUM_LANES - 1)) ? '0 : grant_idx + LANE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`endif

  assign match_hit = |lane_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      match_valid_reg <= 1'b0;
      match_lane_reg  <= '0;
      match_total_reg <= '0;
    end else begin
      match_valid_reg <= match_hit;
      if (match_hit) begin
        match_lane_reg <= grant_idx;
        if (match_total_reg != 8'd255) begin
          match_total_reg <= match_total_reg + 8'd1;
        end
      end
    end
  end

  assign match_valid = match_valid_reg;
  assign match_lane  = match_lane_reg;
  assign match_total = match_total_reg;

endmodule

// File: tb/tb_vehicle_lane_scheduler.sv
// Directed-vector bench for vehicle_lane_scheduler: a table of per-cycle records plus a saturation run.
module tb_vehicle_lane_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] lane_valid;
  logic [3:0] lane_data;
  logic [3:0] lane_clear;
  logic [3:0] lane_ready;
  logic       match_valid;
  logic [1:0] match_lane;
  logic [7:0] match_total;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vehicle_lane_scheduler #(.NUM_LANES(4), .LANE_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .lane_valid (lane_valid),
    .lane_data  (lane_data),
    .lane_clear (lane_clear),
    .lane_ready (lane_ready),
    .match_valid(match_valid),
    .match_lane (match_lane),
    .match_total(match_total)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] v;
    logic [3:0] d;
    logic [3:0] c;
    logic [3:0] er;
    logic       emv;
    logic [1:0] eml;
    logic [7:0] et;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic [3:0] v, logic [3:0] d,
                              logic [3:0] c, logic [3:0] er, logic emv,
                              logic [1:0] eml, logic [7:0] et);
    vec_t t;
    t.name = name; t.rst = rst; t.v = v; t.d = d; t.c = c;
    t.er = er; t.emv = emv; t.eml = eml; t.et = et;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t t, int n);
    reset      = t.rst;
    lane_valid = t.v;
    lane_data  = t.d;
    lane_clear = t.c;
    #1;
    check({t.name, ".ready"}, 32'(lane_ready), 32'(t.er));
    @(posedge clk);
    #1;
    check({t.name, ".mvalid"}, 32'(match_valid), 32'(t.emv));
    check({t.name, ".mlane"},  32'(match_lane),  32'(t.eml));
    check({t.name, ".mtotal"}, 32'(match_total), 32'(t.et));
    $display("vec %0d %s: rst=%b v=%b d=%b c=%b ready=%b mv=%b ml=%0d tot=%0d",
             n, t.name, t.rst, t.v, t.d, t.c, lane_ready, match_valid, match_lane, match_total);
  endtask

  initial begin
    logic pat [5];
    int   exp_tot;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; lane_valid = '0; lane_data = '0; lane_clear = '0;

    //                 name      rst  valid    data     clear    ready  mv    ml     tot
    vecs.push_back(mk("rst0",    1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 8'd0));
    // Single lane 2: B B C B C
    vecs.push_back(mk("l2_s1",   0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0, 2'd0, 8'd0));
    vecs.push_back(mk("l2_s2",   0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0, 2'd0, 8'd0));
    vecs.push_back(mk("l2_s3",   0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, 2'd0, 8'd0));
    vecs.push_back(mk("l2_s4",   0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0, 2'd0, 8'd0));
    vecs.push_back(mk("l2_s5",   0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 8'd1));
    vecs.push_back(mk("idle1",   0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 8'd1));
    // Overlap on lane 1: B B C B B C B C, then B B C B C
    vecs.push_back(mk("ov_1",    0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd2, 8'd1));
    vecs.push_back(mk("ov_2",    0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd2, 8'd1));
    vecs.push_back(mk("ov_3",    0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 2'd2, 8'd1));
    vecs.push_back(mk("ov_4",    0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd2, 8'd1));
    vecs.push_back(mk("ov_5",    0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd2, 8'd1));
    vecs.push_back(mk("ov_6",    0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 2'd2, 8'd1));
    vecs.push_back(mk("ov_7",    0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd2, 8'd1));
    vecs.push_back(mk("ov_8",    0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 8'd2));
    vecs.push_back(mk("ov_9",    0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd1, 8'd2));
    vecs.push_back(mk("ov_10",   0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd1, 8'd2));
    vecs.push_back(mk("ov_11",   0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 2'd1, 8'd2));
    vecs.push_back(mk("ov_12",   0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd1, 8'd2));
    vecs.push_back(mk("ov_13",   0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 8'd3));
    // Fairness: all lanes valid with Car symbols
    vecs.push_back(mk("rst1",    1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 8'd0));
`ifdef VLS_FIXED_PRIORITY_EN
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk($sformatf("rr_%0d", i), 0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
`else
    vecs.push_back(mk("rr_0",    0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("rr_1",    0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 0, 2'd0, 8'd0));
    vecs.push_back(mk("rr_2",    0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 0, 2'd0, 8'd0));
    vecs.push_back(mk("rr_3",    0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 0, 2'd0, 8'd0));
    vecs.push_back(mk("rr_4",    0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("rr_5",    0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 0, 2'd0, 8'd0));
    // Lanes 0 and 3 alternate; each holds its symbol while waiting for its grant.
    vecs.push_back(mk("rst2",    1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 8'd0));
    vecs.push_back(mk("il_1",    0, 4'b1001, 4'b1001, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("il_2",    0, 4'b1001, 4'b1001, 4'b0000, 4'b1000, 0, 2'd0, 8'd0));
    vecs.push_back(mk("il_3",    0, 4'b1001, 4'b1001, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("il_4",    0, 4'b1001, 4'b1000, 4'b0000, 4'b1000, 0, 2'd0, 8'd0));
    vecs.push_back(mk("il_5",    0, 4'b1001, 4'b0000, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("il_6",    0, 4'b1001, 4'b0001, 4'b0000, 4'b1000, 0, 2'd0, 8'd0));
    vecs.push_back(mk("il_7",    0, 4'b1001, 4'b1001, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("il_8",    0, 4'b1001, 4'b1000, 4'b0000, 4'b1000, 0, 2'd0, 8'd0));
    vecs.push_back(mk("il_9",    0, 4'b1001, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 8'd1));
    vecs.push_back(mk("il_10",   0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 2'd3, 8'd2));
    vecs.push_back(mk("idle2",   0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd3, 8'd2));
    // Clear collision on lane 1 sitting in S_BBCB
    vecs.push_back(mk("cl_1",    0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd3, 8'd2));
    vecs.push_back(mk("cl_2",    0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd3, 8'd2));
    vecs.push_back(mk("cl_3",    0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 2'd3, 8'd2));
    vecs.push_back(mk("cl_4",    0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd3, 8'd2));
    vecs.push_back(mk("cl_hit",  0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 2'd3, 8'd2));
    vecs.push_back(mk("cl_c",    0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 2'd3, 8'd2));
    vecs.push_back(mk("cl_p1",   0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd3, 8'd2));
    vecs.push_back(mk("cl_p2",   0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd3, 8'd2));
    vecs.push_back(mk("cl_p3",   0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 2'd3, 8'd2));
    vecs.push_back(mk("cl_p4",   0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 2'd3, 8'd2));
    vecs.push_back(mk("cl_p5",   0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 8'd3));
`endif
    // Mid-stream reset with lane 0 in S_BBCB and a Car pending
    vecs.push_back(mk("rst3",    1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 8'd0));
    vecs.push_back(mk("mr_1",    0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("mr_2",    0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("mr_3",    0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("mr_4",    0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("mr_rst",  1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
    vecs.push_back(mk("mr_c",    0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 2'd0, 8'd0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Saturation: 300 matches on lane 0 starting from a count of zero.
    exp_tot = 0;
    for (int m = 1; m <= 300; m++) begin
      for (int s = 0; s < 5; s++) begin
        reset      = 1'b0;
        lane_valid = 4'b0001;
        lane_data  = {3'b000, pat[s]};
        lane_clear = 4'b0000;
        @(posedge clk);
        #1;
      end
      exp_tot = (exp_tot == 255) ? 255 : exp_tot + 1;
      check($sformatf("sat%0d.mvalid", m), 32'(match_valid), 32'd1);
      check($sformatf("sat%0d.mtotal", m), 32'(match_total), 32'(exp_tot));
      $display("sat %0d: mv=%b ml=%0d tot=%0d", m, match_valid, match_lane, match_total);
    end
    lane_valid = 4'b0000;
    @(posedge clk);
    #1;
    check("sat_end.mvalid", 32'(match_valid), 32'd0);
    check("sat_end.mtotal", 32'(match_total), 32'd255);
    $display("sat_end: mv=%b tot=%0d", match_valid, match_total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vehicle_lane_scheduler.md
# vehicle_lane_scheduler

- Time-multiplexes one vehicle-pattern detection datapath across `NUM_LANES` roadside sensor lanes.
- Arbitrates among lanes presenting a vehicle symbol and accepts one symbol per cycle.
- Holds a saved detector state per lane, so overlapping Bike/Bike/Car/Bike/Car sequences are tracked independently per lane.
- Reports each completed pattern with its lane index; sits between the lane sensor front-ends and the traffic-statistics logic.

## Interface
Parameters:
- `NUM_LANES`, 4: number of requesting lanes (2..16).
- `LANE_W`, 2: width of a lane index; must equal `$clog2(NUM_LANES)`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `lane_valid` in `NUM_LANES`: lane i presents a symbol.
- `lane_data` in `NUM_LANES`: symbol for lane i. 1 = Bike (B), 0 = Car (C).
- `lane_clear` in `NUM_LANES`: lane i's saved state returns to IDLE next edge.
- `lane_ready` out `NUM_LANES`: one-hot or zero grant; combinational.
- `match_valid` out 1: registered pulse, pattern completed.
- `match_lane` out `LANE_W`: lane that completed the pattern.
- `match_total` out 8: saturating count of all matches.

## Operation
- Per-lane state register, 3 bits. Encodings:
  - IDLE = 0
  - S_B = 1
  - S_BB = 2
  - S_BBC = 3
  - S_BBCB = 4
  - S_BBCBC = 5
- Transitions on an accepted symbol, written as state: on B / on C:
  - IDLE: S_B / IDLE
  - S_B: S_BB / IDLE
  - S_BB: S_BB / S_BBC
  - S_BBC: S_BBCB / IDLE
  - S_BBCB: S_BB / S_BBCBC
  - S_BBCBC: S_B / IDLE
  - Encodings 6 and 7: IDLE / IDLE
- Match: a transition into S_BBCBC is a match. Overlap is honoured; e.g. B B C B B C B C yields one match.
- Eligible lane: `lane_valid[i]=1` and `lane_clear[i]=0`.
- Arbitration (round-robin): a pointer `rr_ptr` starts at 0. The grant goes to the first eligible lane at or after `rr_ptr`, wrapping modulo `NUM_LANES`.
- `lane_ready` is high only for the granted lane. The handshake completes when `lane_valid & lane_ready` are both high.
- Pointer update:
  - On a grant to lane g, `rr_ptr` becomes (g+1) mod `NUM_LANES`.
  - With no grant, `rr_ptr` holds.
- Only the granted lane's state updates. All other lanes hold, except lanes with `lane_clear` set, which go to IDLE.
- Clear and valid on the same lane in the same cycle: clear wins. The lane is not granted, its symbol is not consumed, and its state becomes IDLE.
- Upstream must hold `lane_data[i]` stable while `lane_valid[i]` is high and ready is low.
- `match_total` increments by 1 per match and saturates at 255.
- Reset, including mid-operation, sets:
  - all lane states to IDLE
  - `rr_ptr` = 0
  - `match_valid` = 0
  - `match_lane` = 0
  - `match_total` = 0
  - Any pending handshake is discarded.

## Timing
- `lane_ready` is combinational from `lane_valid`, `lane_clear` and `rr_ptr`. It has no dependency on `lane_ready` itself.
- Throughput: one symbol per cycle aggregate across all lanes.
- Latency: for a symbol accepted at edge N, the lane state updates at edge N.
  - `match_valid`/`match_lane` are registered at edge N and are visible during cycle N+1 for exactly one cycle, unless the next accepted symbol also matches.
  - `match_total` updates at the same edge N.
- Back-to-back matches on different lanes in consecutive cycles produce consecutive `match_valid` pulses, each carrying the correct `match_lane`.
- When `match_valid` = 0, `match_lane` holds its last value.

## Configuration
- `VLS_FIXED_PRIORITY_EN`:
  - Defined: fixed priority; the lowest-index eligible lane always wins, and `rr_ptr` is not implemented and not updated.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset check: assert `reset` mid-stream after lane 0 reaches S_BBCB. Required: `match_valid`=0, `match_total`=0; then lane 0 feeding C alone produces no match.
- Single lane, lane 2 only valid, symbols 1,1,0,1,0. Required: `lane_ready[2]`=1 on every cycle; one `match_valid` pulse with `match_lane`=2 in the cycle after the 5th accept; `match_total`=1.
- Overlap, lane 1 stream 1,1,0,1,1,0,1,0. Required: exactly one match. Then continuing 1,1,0,1,0 gives a second match; `match_total`=2.
- Round-robin fairness: all 4 lanes valid continuously from reset. Required: grants in order 0,1,2,3,0,1 on successive cycles. With `VLS_FIXED_PRIORITY_EN` defined, the grant is always lane 0.
- Interleaved contexts: lanes 0 and 3 each send 1,1,0,1,0, alternating. Required: per-lane states are kept independent, giving two matches (lane 0 then lane 3) one cycle apart.
- Clear collision: lane 1 is in S_BBCB, `lane_valid[1]`=1 with data 0, and `lane_clear[1]`=1. Required: `lane_ready[1]`=0, no match, lane 1 returns to IDLE. 300 forced matches leave `match_total`=255.
